ddram_line_ctl: RTL and testbench
=================================

DDRAM_LINE_CTL -- requirements
Module: ddram_line_ctl

Interface
REQ-001 SHALL have parameter NCH, default 2: number of read line buffers (≥1).
REQ-002 SHALL have parameter MAX_BURST, default 15: maximum beats per read burst (1..255).
REQ-003 SHALL have parameter BASE_ADDR, 29 bits, default 29'h0380_0000: 64-bit-word base added to every DDR address.
REQ-004 SHALL define CW = max(1, clog2(NCH)).
REQ-005 Ports, with clock and reset first:
- DDRAM_CLK  in  1  sole clock.
- DDRAM_RST_N  in  1  synchronous, active-low reset.
- DDRAM_BUSY  in  1  DDR stall.
- DDRAM_BURSTCNT  out  8  beats.
- DDRAM_ADDR  out  29  word address.
- DDRAM_DOUT  in  64  read data.
- DDRAM_DOUT_READY  in  1  read beat valid.
- DDRAM_RD  out  1  read command.
- DDRAM_DIN  out  64  write data.
- DDRAM_BE  out  8  byte enables.
- DDRAM_WE  out  1  write command.
- mem_addr  in  27  [27:1] byte address.
- mem_din  in  64  write data.
- mem_be  in  8  write byte enables.
- mem_wr  in  1  write request, rising edge.
- mem_rd  in  1  read request, rising edge.
- mem_rd_ch  in  CW  destination line buffer.
- mem_burst  in  8  read beats.
- mem_busy  out  1  request pending.
- mem_dready  out  1  read-done pulse.
- mem_err  out  1  rejected-request pulse.
- mem_dout  out  64  first beat of last read.
- mem_line_ch  in  CW  line buffer select.
- mem_line_dout  out  64*MAX_BURST  selected line, beat k at [64k+:64].

Function
REQ-006 SHALL latch pending flags wr_req/rd_req on rising edges of mem_wr/mem_rd, each edge-detected against a one-cycle delayed copy; flags SHALL set regardless of DDRAM_BUSY.
REQ-007 SHALL capture mem_addr, mem_din, mem_be, mem_rd_ch and mem_burst in the cycle the command is issued from IDLE; inputs SHALL be held stable while mem_busy=1.
REQ-008 SHALL implement FSM IDLE, WR, RD_CMD and RD_BEAT; IDLE, WR and RD_CMD SHALL advance only when DDRAM_BUSY=0.
REQ-009 SHALL, in IDLE with wr_req=1, assert DDRAM_WE for exactly one non-busy cycle with BURSTCNT=1, then go to WR; WR SHALL clear wr_req and return to IDLE.
REQ-010 SHALL serve a write first when wr_req and rd_req are both set; the read SHALL follow without being lost.
REQ-011 SHALL, in IDLE with rd_req=1 and mem_burst in 1..MAX_BURST, assert DDRAM_RD for one non-busy cycle with BURSTCNT=mem_burst, then go to RD_CMD.
REQ-012 SHALL, in IDLE with rd_req=1 and mem_burst=0 or >MAX_BURST, issue no command, clear rd_req and pulse mem_err for 1 cycle.
REQ-013 SHALL drive DDRAM_ADDR = BASE_ADDR + zero-extended mem_addr[27:3], modulo 2^29.
REQ-014 SHALL store beat k (0-based) into buffer mem_rd_ch at slot k on each DOUT_READY cycle in RD_CMD/RD_BEAT, independent of DDRAM_BUSY; beat 0 SHALL also load mem_dout.
REQ-015 SHALL, on the beat whose index equals burst-1, return to IDLE, clear rd_req and pulse mem_dready for exactly one cycle after the final write to the line buffer.
REQ-016 SHALL leave slots above the burst length unchanged.
REQ-017 SHALL set mem_busy = wr_req OR rd_req.
REQ-018 SHALL make mem_line_dout a combinational mux of the buffer selected by mem_line_ch; a buffer SHALL be readable while another is being filled.
REQ-019 SHALL ignore DOUT_READY in IDLE and WR.
REQ-020 SHALL set DDRAM_BE=8'hFF whenever DDRAM_RD=1.

Reset
REQ-021 SHALL, while DDRAM_RST_N=0 at a clock edge, enter IDLE and clear wr_req, rd_req, DDRAM_RD, DDRAM_WE, mem_dready, mem_err, the beat index and the edge-detect registers; a burst in flight SHALL be abandoned and its remaining beats ignored.
REQ-022 SHALL NOT clear line buffers or mem_dout on reset; their power-up value SHALL be 0.
REQ-023 SHALL NOT register a mem_rd/mem_wr level already high at reset release as an edge.

Configuration
REQ-024 With macro DDRAM_LINE_CTL_BE_EN defined, writes SHALL drive DDRAM_BE = latched mem_be; undefined, write BE SHALL be 8'hFF, and mem_be SHALL remain a port but be ignored.

Verification
REQ-025 Write addr 27'h0000010, din 64'hA5 -> one WE pulse, ADDR=29'h0380_0002, BURSTCNT=1, then mem_busy falls.
REQ-026 Read burst 4 into ch 1, BUSY high 3 cycles at issue -> RD held until accepted; slots 0..3 of buffer 1 filled, mem_dready one pulse, buffer 0 unchanged.
REQ-027 mem_wr and mem_rd rising in the same cycle -> WE issued before RD; both complete, mem_busy then 0.
REQ-028 Read with burst 0, then burst 16 (MAX_BURST=15) -> no DDRAM_RD, two mem_err pulses, mem_busy returns 0.
REQ-029 Reset asserted after beat 2 of 8 -> IDLE; later DOUT_READY ignored; the next read completes normally.
REQ-030 With BE_EN, write mem_be=8'h0F -> DDRAM_BE=8'h0F; without BE_EN -> 8'hFF.

Source files
------------

// File: rtl/ddram_line_ctl.sv
// ---------------------------------------------------------------------------
// ddram_line_ctl
//
// Single-port DDR client that turns edge-triggered write / burst-read
// requests into DDRAM (Avalon-style) commands and collects read bursts into
// NCH line buffers.
//
// Commands are registered.
//   - A write puts DDRAM_WE up for one accepted cycle with BURSTCNT=1.
//   - A read puts DDRAM_RD up with BURSTCNT=mem_burst.
// Either command is held while DDRAM_BUSY is high.
//
// Returned beats are stored by index into the line buffer chosen at issue
// time. The whole selected line is presented combinationally on
// mem_line_dout.
//
// Optional feature macro: DDRAM_LINE_CTL_BE_EN
//   defined   : write byte enables come from mem_be
//   undefined : writes use 8'hFF and mem_be is ignored
//
// Parameters
//   NCH        number of read line buffers (>= 1)
//   MAX_BURST  maximum beats per read burst (1..255)
//   BASE_ADDR  64-bit-word base added to every DDR address
//   CW         width of the line-buffer select, max(1, clog2(NCH))
//
// Ports
//   DDRAM_CLK         sole clock
//   DDRAM_RST_N       synchronous active-low reset
//   DDRAM_BUSY        DDR stall; commands are held while high
//   DDRAM_BURSTCNT    beats of the current command
//   DDRAM_ADDR        64-bit word address
//   DDRAM_DOUT        read data beat
//   DDRAM_DOUT_READY  read beat valid
//   DDRAM_RD          read command
//   DDRAM_DIN         write data
//   DDRAM_BE          byte enables
//   DDRAM_WE          write command
//   mem_addr          byte address bits [27:1]
//   mem_din           write data
//   mem_be            write byte enables
//   mem_wr            write request (rising edge)
//   mem_rd            read request (rising edge)
//   mem_rd_ch         destination line buffer of a read
//   mem_burst         read burst length in beats
//   mem_busy          a request is pending
//   mem_dready        one-cycle pulse when a read burst has been stored
//   mem_err           one-cycle pulse when a read is rejected (bad burst)
//   mem_dout          first beat of the most recent read
//   mem_line_ch       line buffer shown on mem_line_dout
//   mem_line_dout     selected line; beat k at [64k +: 64]
// ---------------------------------------------------------------------------
module ddram_line_ctl #(
  parameter int          NCH       = 2,
  parameter int          MAX_BURST = 15,
  parameter logic [28:0] BASE_ADDR = 29'h0380_0000,
  localparam int         CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                     DDRAM_CLK,
  input  logic                     DDRAM_RST_N,
  input  logic                     DDRAM_BUSY,
  output logic [7:0]               DDRAM_BURSTCNT,
  output logic [28:0]              DDRAM_ADDR,
  input  logic [63:0]              DDRAM_DOUT,
  input  logic                     DDRAM_DOUT_READY,
  output logic                     DDRAM_RD,
  output logic [63:0]              DDRAM_DIN,
  output logic [7:0]               DDRAM_BE,
  output logic                     DDRAM_WE,
  input  logic [27:1]              mem_addr,
  input  logic [63:0]              mem_din,
  input  logic [7:0]               mem_be,
  input  logic                     mem_wr,
  input  logic                     mem_rd,
  input  logic [CW-1:0]            mem_rd_ch,
  input  logic [7:0]               mem_burst,
  output logic                     mem_busy,
  output logic                     mem_dready,
  output logic                     mem_err,
  output logic [63:0]              mem_dout,
  input  logic [CW-1:0]            mem_line_ch,
  output logic [64*MAX_BURST-1:0]  mem_line_dout
);

  localparam logic [7:0] MAX_B8 = 8'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_CMD  = 2'd2,
    RD_BEAT = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Request edge detection
  logic wr_d_reg, rd_d_reg;
  logic armed_reg;
  logic wr_edge, rd_edge;
  logic wr_req_reg, rd_req_reg;

  // Command registers
  logic        we_reg, rd_reg;
  logic [7:0]  burstcnt_reg;
  logic [28:0] addr_reg;
  logic [63:0] din_reg;
  logic [7:0]  be_reg;
  logic [CW-1:0] ch_reg;
  logic [7:0]  burst_reg;
  logic [7:0]  beat_idx_reg;

  logic        dready_reg, err_reg;
  logic [63:0] dout_reg = '0;

  // FSM strobes
  logic issue_wr, issue_rd, reject, wr_done, cmd_accept;
  logic beat_valid, last_beat;
  logic burst_ok;
  logic [28:0] word_addr;
  logic [7:0]  wr_be;
  logic        unused_bits;

  // Line buffers, one 64-bit register per (channel, slot)
  logic [NCH-1:0][MAX_BURST-1:0][63:0] line_all;

  assign word_addr = BASE_ADDR + {4'd0, mem_addr[27:3]};
  assign burst_ok  = (mem_burst != 8'd0) && (mem_burst <= MAX_B8);

`ifdef DDRAM_LINE_CTL_BE_EN
  assign wr_be       = mem_be;
  assign unused_bits = ^mem_addr[2:1];
`else
  assign wr_be       = 8'hFF;
  assign unused_bits = ^{mem_be, mem_addr[2:1]};
`endif

  // The first cycle after reset release only loads the delayed copies.
  // A request level that is already high at release therefore never looks
  // like a fresh edge.
  assign wr_edge = armed_reg && mem_wr && !wr_d_reg;
  assign rd_edge = armed_reg && mem_rd && !rd_d_reg;

  // Beats are only taken while a read is outstanding. They are never taken
  // on a reset edge, so a burst abandoned by reset leaves no trace.
  assign beat_valid = DDRAM_RST_N && DDRAM_DOUT_READY &&
                      ((state_reg == RD_CMD) || (state_reg == RD_BEAT));
  assign last_beat  = beat_valid && (beat_idx_reg == burst_reg - 8'd1);

  // --------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------
  always_ff @(posedge DDRAM_CLK) begin
    if (!DDRAM_RST_N) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    issue_wr   = 1'b0;
    issue_rd   = 1'b0;
    reject     = 1'b0;
    wr_done    = 1'b0;
    cmd_accept = 1'b0;
    case (state_reg)
      IDLE: begin
        // A pending write always goes first; the read stays pending.
        if (wr_req_reg) begin
          if (!DDRAM_BUSY) begin
            issue_wr   = 1'b1;
            state_next = WR;
          end
        end else if (rd_req_reg) begin
          if (!burst_ok) begin
            reject = 1'b1;
          end else if (!DDRAM_BUSY) begin
            issue_rd   = 1'b1;
            state_next = RD_CMD;
          end
        end
      end
      WR: begin
        if (!DDRAM_BUSY) begin
          wr_done    = 1'b1;
          state_next = IDLE;
        end
      end
      RD_CMD: begin
        // A final beat, even one arriving before the accept, ends the read.
        if (last_beat) begin
          state_next = IDLE;
        end else if (!DDRAM_BUSY) begin
          cmd_accept = 1'b1;
          state_next = RD_BEAT;
        end
      end
      RD_BEAT: begin
        if (last_beat) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------
  // Request flags, command strobes, beat index
  // --------------------------------------------------------------------
  always_ff @(posedge DDRAM_CLK) begin
    if (!DDRAM_RST_N) begin
      armed_reg    <= 1'b0;
      wr_d_reg     <= 1'b0;
      rd_d_reg     <= 1'b0;
      wr_req_reg   <= 1'b0;
      rd_req_reg   <= 1'b0;
      we_reg       <= 1'b0;
      rd_reg       <= 1'b0;
      dready_reg   <= 1'b0;
      err_reg      <= 1'b0;
      beat_idx_reg <= 8'd0;
    end else begin
      armed_reg <= 1'b1;
      wr_d_reg  <= mem_wr;
      rd_d_reg  <= mem_rd;

      // A new edge wins over a clear in the same cycle, so it is not lost.
      wr_req_reg <= (wr_req_reg && !wr_done) || wr_edge;
      rd_req_reg <= (rd_req_reg && !(reject || last_beat)) || rd_edge;

      if (issue_wr) begin
        we_reg <= 1'b1;
      end else if (wr_done) begin
        we_reg <= 1'b0;
      end

      if (issue_rd) begin
        rd_reg <= 1'b1;
      end else if (cmd_accept || last_beat) begin
        rd_reg <= 1'b0;
      end

      if (issue_rd) begin
        beat_idx_reg <= 8'd0;
      end else if (beat_valid) begin
        beat_idx_reg <= beat_idx_reg + 8'd1;
      end

      // Registered so the pulse follows the final line-buffer write.
      dready_reg <= last_beat;
      err_reg    <= reject;
    end
  end

  // Command fields are captured on issue and need no reset.
  always_ff @(posedge DDRAM_CLK) begin
    if (issue_wr) begin
      addr_reg     <= word_addr;
      din_reg      <= mem_din;
      be_reg       <= wr_be;
      burstcnt_reg <= 8'd1;
    end else if (issue_rd) begin
      addr_reg     <= word_addr;
      be_reg       <= 8'hFF;
      burstcnt_reg <= mem_burst;
      burst_reg    <= mem_burst;
      ch_reg       <= mem_rd_ch;
    end
  end

  // mem_dout survives reset and powers up as zero.
  always_ff @(posedge DDRAM_CLK) begin
    if (beat_valid && (beat_idx_reg == 8'd0)) begin
      dout_reg <= DDRAM_DOUT;
    end
  end

  // --------------------------------------------------------------------
  // Line buffers: survive reset, power up as zero. Slots beyond the
  // current burst length are never addressed, so they keep old data.
  // --------------------------------------------------------------------
  genvar gi, gj;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      for (gj = 0; gj < MAX_BURST; gj++) begin : g_slot
        logic [63:0] slot_reg = '0;
        always_ff @(posedge DDRAM_CLK) begin
          if (beat_valid && (ch_reg == CW'(gi)) && (beat_idx_reg == 8'(gj))) begin
            slot_reg <= DDRAM_DOUT;
          end
        end
        assign line_all[gi][gj] = slot_reg;
      end
    end
  endgenerate

  // An out-of-range select shows buffer 0.
  always_comb begin
    mem_line_dout = line_all[0];
    for (int i = 1; i < NCH; i++) begin
      if (mem_line_ch == CW'(i)) begin
        mem_line_dout = line_all[i];
      end
    end
  end

  // --------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------
  assign DDRAM_WE       = we_reg;
  assign DDRAM_RD       = rd_reg;
  assign DDRAM_ADDR     = addr_reg;
  assign DDRAM_DIN      = din_reg;
  assign DDRAM_BE       = be_reg;
  assign DDRAM_BURSTCNT = burstcnt_reg;
  assign mem_busy       = wr_req_reg || rd_req_reg;
  assign mem_dready     = dready_reg;
  assign mem_err        = err_reg;
  assign mem_dout       = dout_reg;

endmodule

// File: tb/tb_ddram_line_ctl.sv
// Testbench for ddram_line_ctl: scoreboard of expected DDR commands and
// read completions, plus a model of the line buffers.
module tb_ddram_line_ctl;

  localparam int          NCH       = 2;
  localparam int          MAX_BURST = 15;
  localparam int          CW        = 1;
  localparam logic [28:0] BASE      = 29'h0380_0000;

  logic clk = 1'b0;
  logic rst_n;
  logic ddr_busy;
  logic [7:0] ddr_burstcnt;
  logic [28:0] ddr_addr;
  logic [63:0] ddr_dout;
  logic ddr_dout_ready;
  logic ddr_rd;
  logic [63:0] ddr_din;
  logic [7:0] ddr_be;
  logic ddr_we;
  logic [27:1] mem_addr;
  logic [63:0] mem_din;
  logic [7:0] mem_be;
  logic mem_wr, mem_rd;
  logic [CW-1:0] mem_rd_ch;
  logic [7:0] mem_burst;
  logic mem_busy, mem_dready, mem_err;
  logic [63:0] mem_dout;
  logic [CW-1:0] mem_line_ch;
  logic [64*MAX_BURST-1:0] mem_line_dout;

  always #5 clk = ~clk;

  ddram_line_ctl #(
    .NCH(NCH),
    .MAX_BURST(MAX_BURST),
    .BASE_ADDR(BASE)
  ) dut (
    .DDRAM_CLK(clk),
    .DDRAM_RST_N(rst_n),
    .DDRAM_BUSY(ddr_busy),
    .DDRAM_BURSTCNT(ddr_burstcnt),
    .DDRAM_ADDR(ddr_addr),
    .DDRAM_DOUT(ddr_dout),
    .DDRAM_DOUT_READY(ddr_dout_ready),
    .DDRAM_RD(ddr_rd),
    .DDRAM_DIN(ddr_din),
    .DDRAM_BE(ddr_be),
    .DDRAM_WE(ddr_we),
    .mem_addr(mem_addr),
    .mem_din(mem_din),
    .mem_be(mem_be),
    .mem_wr(mem_wr),
    .mem_rd(mem_rd),
    .mem_rd_ch(mem_rd_ch),
    .mem_burst(mem_burst),
    .mem_busy(mem_busy),
    .mem_dready(mem_dready),
    .mem_err(mem_err),
    .mem_dout(mem_dout),
    .mem_line_ch(mem_line_ch),
    .mem_line_dout(mem_line_dout)
  );

  typedef struct packed {
    logic        is_wr;
    logic [28:0] addr;
    logic [7:0]  cnt;
    logic [63:0] din;
    logic [7:0]  be;
  } cmd_t;

  cmd_t        cmd_q[$];
  logic [63:0] rd_q[$];     // expected first beat of each completed read

  logic [63:0] exp_line [NCH][MAX_BURST];
  logic [63:0] exp_dout;

  int total = 0;
  int bad   = 0;
  int we_acc = 0, rd_acc = 0, dready_cnt = 0, err_cnt = 0;
  int exp_we = 0, exp_rd = 0, exp_dready = 0, exp_err = 0;

  cmd_t        mon_c;
  logic [63:0] mon_first;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] be_exp(input logic [7:0] be);
`ifdef DDRAM_LINE_CTL_BE_EN
    return be;
`else
    return 8'hFF | be;   // all lanes enabled regardless of mem_be
`endif
  endfunction

  function automatic logic [28:0] word_of(input logic [27:0] ba);
    return BASE + {4'd0, ba[27:3]};
  endfunction

  // Monitor: commands are accepted at a posedge where RD/WE is high and
  // BUSY is low; both are stable at the preceding negedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if ((ddr_we || ddr_rd) && !ddr_busy) begin
        check("cmd_expected", 64'(cmd_q.size() != 0), 64'd1);
        if (cmd_q.size() != 0) begin
          mon_c = cmd_q.pop_front();
          check("cmd_we", 64'(ddr_we), 64'(mon_c.is_wr));
          check("cmd_rd", 64'(ddr_rd), 64'(!mon_c.is_wr));
          check("cmd_addr", 64'(ddr_addr), 64'(mon_c.addr));
          check("cmd_burstcnt", 64'(ddr_burstcnt), 64'(mon_c.cnt));
          check("cmd_be", 64'(ddr_be), 64'(mon_c.be));
          if (mon_c.is_wr) check("cmd_din", ddr_din, mon_c.din);
        end
        if (ddr_we) we_acc++;
        if (ddr_rd) rd_acc++;
      end
      if (mem_dready) begin
        dready_cnt++;
        check("dready_expected", 64'(rd_q.size() != 0), 64'd1);
        if (rd_q.size() != 0) begin
          mon_first = rd_q.pop_front();
          check("mem_dout", mem_dout, mon_first);
        end
      end
      if (mem_err) err_cnt++;
    end
  end

  task automatic wait_idle(input string tag);
    int n = 0;
    while (mem_busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 64'(mem_busy), 64'd0);
  endtask

  task automatic check_lines(input string tag);
    for (int c = 0; c < NCH; c++) begin
      mem_line_ch = CW'(c);
      #1;
      for (int k = 0; k < MAX_BURST; k++) begin
        check($sformatf("%s_ch%0d_slot%0d", tag, c, k),
              mem_line_dout[64*k +: 64], exp_line[c][k]);
      end
    end
  endtask

  task automatic do_write(input logic [27:0] ba, input logic [63:0] din,
                          input logic [7:0] be, input logic [28:0] exp_addr);
    cmd_t c;
    c.is_wr = 1'b1; c.addr = exp_addr; c.cnt = 8'd1; c.din = din; c.be = be_exp(be);
    cmd_q.push_back(c);
    exp_we++;
    mem_addr = ba[27:1]; mem_din = din; mem_be = be; mem_wr = 1'b1;
    @(posedge clk); #1;
    mem_wr = 1'b0;
    wait_idle("wr_busy_falls");
    repeat (2) @(posedge clk);
    #1;
    check("we_count", 64'(we_acc), 64'(exp_we));
    $display("write ba=%h din=%h be=%h addr=%h", ba, din, be, exp_addr);
  endtask

  // Read of `burst` beats into `ch`. Optionally raises a write in the same
  // cycle, stalls with BUSY for `busy` cycles once RD is up, and/or resets
  // the DUT after `abort_at` beats (0 = no abort).
  task automatic do_read(input int ch, input int burst, input int busy,
                         input logic [27:0] ba, input bit with_wr,
                         input logic [63:0] wdin, input int abort_at);
    cmd_t c;
    int n, nb, other;
    logic [63:0] d;
    other = (ch + 1) % NCH;
    if (with_wr) begin
      c.is_wr = 1'b1; c.addr = word_of(ba); c.cnt = 8'd1; c.din = wdin; c.be = be_exp(8'h3C);
      cmd_q.push_back(c);
      exp_we++;
    end
    c.is_wr = 1'b0; c.addr = word_of(ba); c.cnt = 8'(burst); c.din = 64'd0; c.be = 8'hFF;
    cmd_q.push_back(c);
    exp_rd++;
    mem_addr = ba[27:1]; mem_din = wdin; mem_be = 8'h3C;
    mem_rd_ch = CW'(ch); mem_burst = 8'(burst);
    mem_rd = 1'b1;
    mem_wr = with_wr;
    @(posedge clk); #1;
    mem_rd = 1'b0; mem_wr = 1'b0;
    n = 0;
    while (!ddr_rd && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("rd_seen", 64'(ddr_rd), 64'd1);
    ddr_busy = (busy > 0);
    for (int i = 0; i < busy; i++) begin
      @(negedge clk);
      check("rd_held", 64'(ddr_rd), 64'd1);
      @(posedge clk); #1;
    end
    ddr_busy = 1'b0;
    @(posedge clk); #1;   // command accepted at this edge
    nb = (abort_at != 0) ? abort_at : burst;
    for (int k = 0; k < nb; k++) begin
      d = {$urandom, $urandom};
      ddr_dout = d; ddr_dout_ready = 1'b1;
      exp_line[ch][k] = d;
      if (k == 0) begin
        exp_dout = d;
        if (abort_at == 0) begin
          rd_q.push_back(d);
          exp_dready++;
        end
      end
      @(posedge clk); #1;
      if (k == 0) begin
        // Another buffer stays readable while this one fills.
        mem_line_ch = CW'(other);
        #1;
        check("line_other_during_fill", mem_line_dout[63:0], exp_line[other][0]);
      end
    end
    ddr_dout_ready = 1'b0;
    if (abort_at != 0) begin
      mem_wr = 1'b1;   // level already high across reset release
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = nb; k < burst; k++) begin
        ddr_dout = {$urandom, $urandom}; ddr_dout_ready = 1'b1;
        @(posedge clk); #1;
      end
      ddr_dout_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("no_edge_at_release", 64'(mem_busy), 64'd0);
      mem_wr = 1'b0;
    end
    wait_idle("rd_busy_falls");
    repeat (3) @(posedge clk);
    #1;
    check("dready_count", 64'(dready_cnt), 64'(exp_dready));
    check("rd_count", 64'(rd_acc), 64'(exp_rd));
    check("we_count_rd", 64'(we_acc), 64'(exp_we));
    check("mem_dout_model", mem_dout, exp_dout);
    check_lines("line");
    $display("read ch=%0d burst=%0d busy=%0d wr=%0d abort=%0d", ch, burst, busy, with_wr, abort_at);
  endtask

  task automatic do_bad_read(input int burst);
    mem_burst = 8'(burst); mem_rd_ch = '0;
    mem_rd = 1'b1;
    exp_err++;
    @(posedge clk); #1;
    mem_rd = 1'b0;
    wait_idle("err_busy_falls");
    repeat (2) @(posedge clk);
    #1;
    check("err_count", 64'(err_cnt), 64'(exp_err));
    check("err_no_rd", 64'(rd_acc), 64'(exp_rd));
    $display("bad read burst=%0d", burst);
  endtask

  initial begin
    rst_n = 1'b0;
    ddr_busy = 1'b0; ddr_dout = '0; ddr_dout_ready = 1'b0;
    mem_addr = '0; mem_din = '0; mem_be = '0; mem_wr = 1'b0; mem_rd = 1'b0;
    mem_rd_ch = '0; mem_burst = '0; mem_line_ch = '0;
    exp_dout = '0;
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < MAX_BURST; k++)
        exp_line[c][k] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd", 64'(ddr_rd), 64'd0);
    check("rst_we", 64'(ddr_we), 64'd0);
    check("rst_busy", 64'(mem_busy), 64'd0);
    check("rst_dready", 64'(mem_dready), 64'd0);
    check("rst_err", 64'(mem_err), 64'd0);
    check("rst_dout", mem_dout, 64'd0);
    check_lines("powerup");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Byte address 0x10 -> word 2 above the base.
    do_write(28'h0000010, 64'h0000_0000_0000_00A5, 8'h0F, 29'h0380_0002);
    do_write(28'hFFFFFF8, 64'h1234_5678_9ABC_DEF0, 8'hF0, 29'h057F_FFFF);

    do_read(1, 4, 3, 28'h0000100, 1'b0, 64'd0, 0);
    do_read(0, MAX_BURST, 0, 28'h0000200, 1'b0, 64'd0, 0);
    do_read(1, 1, 1, 28'h0000300, 1'b0, 64'd0, 0);
    do_read(0, 5, 0, 28'h0000400, 1'b1, 64'hDEAD_BEEF_0BAD_F00D, 0);

    do_bad_read(0);
    do_bad_read(MAX_BURST + 1);

    do_read(0, 8, 0, 28'h0000500, 1'b0, 64'd0, 2);
    do_read(0, 8, 0, 28'h0000600, 1'b0, 64'd0, 0);

    check("cmd_q_drained", 64'(cmd_q.size()), 64'd0);
    check("rd_q_drained", 64'(rd_q.size()), 64'd0);
    check("err_total", 64'(err_cnt), 64'(exp_err));
    check("final_busy", 64'(mem_busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
